// File: rtl/sign_text_buffer_if.sv
// Frame-code input and character-output bundle for the sign text buffer.
// Pure wiring: no storage or added latency.
// The char_valid/char_ready pair carries backpressure; sign_valid cannot be stalled.
interface sign_text_buffer_if #(
    parameter int SIGN_W     = 8,
    parameter int FIFO_DEPTH = 8
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [SIGN_W-1:0] sign_value;
    logic              sign_valid;
    logic [SIGN_W-1:0] char_out;
    logic              char_valid;
    logic              char_ready;
    logic [CW-1:0]     fifo_count;
    logic              overflow;

    modport slave (
        input  sign_value, sign_valid, char_ready,
        output char_out, char_valid, fifo_count, overflow
    );

    modport master (
        output sign_value, sign_valid, char_ready,
        input  char_out, char_valid, fifo_count, overflow
    );
endinterface

// File: rtl/sign_text_buffer.sv
// Debounces per-frame sign codes and queues each accepted character in a FWFT FIFO.
// Accepted character is visible one cycle after the qualifying sign_valid edge.
// char_ready low holds char_out; a push into a full FIFO with no pop is dropped and sets overflow.
module sign_text_buffer #(
    parameter int                SIGN_W        = 8,
    parameter int                STABLE_FRAMES = 4,
    parameter int                FIFO_DEPTH    = 8,
    parameter logic [SIGN_W-1:0] NONE_CODE     = '0
) (
    input logic            clk,
    input logic            rst,
    sign_text_buffer_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [7:0]    STABLE_MAX = 8'(STABLE_FRAMES);
    localparam logic [CW-1:0] FULL_CNT   = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, TRACK, LOCKED} state_t;

    state_t            state, state_nxt;
    logic [SIGN_W-1:0] candidate, candidate_nxt;
    logic [7:0]        stable_cnt, stable_cnt_nxt;
    logic [7:0]        stable_inc;
    logic              push;

    logic [SIGN_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     rd_ptr, wr_ptr;
    logic [CW-1:0]     count;
    logic              overflow_q;
    logic              full, pop, do_write;

    assign stable_inc = stable_cnt + 8'd1;

    // Debounce state register; updates only matter on frame strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            candidate  <= NONE_CODE;
            stable_cnt <= 8'd0;
        end else begin
            state      <= state_nxt;
            candidate  <= candidate_nxt;
            stable_cnt <= stable_cnt_nxt;
        end
    end

    // Next-state: a new code restarts the run; TRACK pushes once the run reaches STABLE_FRAMES.
    always_comb begin
        state_nxt      = state;
        candidate_nxt  = candidate;
        stable_cnt_nxt = stable_cnt;
        push           = 1'b0;
        if (bus.sign_valid) begin
            if (bus.sign_value != candidate) begin
                candidate_nxt  = bus.sign_value;
                stable_cnt_nxt = 8'd1;
                if (bus.sign_value == NONE_CODE) begin
                    state_nxt = IDLE;
                end else if (STABLE_FRAMES == 1) begin
                    push      = 1'b1;
                    state_nxt = LOCKED;
                end else begin
                    state_nxt = TRACK;
                end
            end else if (state == TRACK) begin
                stable_cnt_nxt = stable_inc;
                if (stable_inc == STABLE_MAX) begin
                    push      = 1'b1;
                    state_nxt = LOCKED;
                end
            end
        end
    end

    assign full     = (count == FULL_CNT);
    assign pop      = (count != '0) && bus.char_ready;
    assign do_write = push && (!full || pop);

    // Character FIFO: storage cleared on reset so char_out reads 0 until the first write.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (do_write) begin
                mem[wr_ptr] <= candidate_nxt;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            if (do_write && !pop)      count <= count + CW'(1);
            else if (pop && !do_write) count <= count - CW'(1);
            if (push && full && !pop) overflow_q <= 1'b1;
        end
    end

    assign bus.char_out   = mem[rd_ptr];
    assign bus.char_valid = (count != '0);
    assign bus.fifo_count = count;
    assign bus.overflow   = overflow_q;
endmodule

// File: tb/tb_sign_text_buffer.sv
// Bench for sign_text_buffer: directed test-plan steps plus a random soak,
// all checked every cycle against a run-length / queue reference model.
module tb_sign_text_buffer;
    localparam int STABLE = 4;
    localparam int DEPTH  = 8;
    localparam logic [7:0] NONE = 8'h00;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    sign_text_buffer_if #(.SIGN_W(8), .FIFO_DEPTH(DEPTH)) bus ();

    sign_text_buffer #(
        .SIGN_W(8), .STABLE_FRAMES(STABLE), .FIFO_DEPTH(DEPTH), .NONE_CODE(NONE)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: last code seen, length of its run, whether the run already emitted.
    logic [7:0] m_last = NONE;
    int         m_run = 0;
    bit         m_emitted = 0;
    logic [7:0] m_q [$];
    bit         m_ovf = 0;
    bit         m_zero_out = 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input logic [7:0] v, input logic vv, input logic rdy, input logic r);
        bit pop;
        bit push;
        if (r) begin
            m_q.delete();
            m_ovf = 0; m_last = NONE; m_run = 0; m_emitted = 0; m_zero_out = 1;
        end else begin
            pop  = (m_q.size() != 0) && rdy;
            push = 0;
            if (vv) begin
                if (v != m_last) begin
                    m_last = v; m_run = 1; m_emitted = 0;
                end else begin
                    m_run++;
                end
                if (v != NONE && !m_emitted && m_run >= STABLE) begin
                    push = 1; m_emitted = 1;
                end
            end
            if (pop) void'(m_q.pop_front());
            if (push) begin
                if (m_q.size() < DEPTH) begin
                    m_q.push_back(v);
                    m_zero_out = 0;
                end else begin
                    m_ovf = 1;
                end
            end
        end
    endtask

    task automatic tick(input logic [7:0] v, input logic vv, input logic rdy, input logic r);
        bus.sign_value = v;
        bus.sign_valid = vv;
        bus.char_ready = rdy;
        rst            = r;
        @(posedge clk);
        model_edge(v, vv, rdy, r);
        #1;
        check("char_valid", 32'(bus.char_valid), 32'(m_q.size() != 0));
        check("fifo_count", 32'(bus.fifo_count), 32'(m_q.size()));
        check("overflow",   32'(bus.overflow),   32'(m_ovf));
        if (m_q.size() != 0) check("char_out", 32'(bus.char_out), 32'(m_q[0]));
        else if (m_zero_out) check("char_out_zero", 32'(bus.char_out), 32'h0);
    endtask

    task automatic frame(input logic [7:0] v, input logic rdy);
        tick(v, 1'b1, rdy, 1'b0);
    endtask

    task automatic gap(input logic rdy);
        tick(8'($urandom), 1'b0, rdy, 1'b0);
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) tick(8'($urandom), 1'($urandom), 1'($urandom), 1'b1);
        check("reset_count", 32'(bus.fifo_count), 32'h0);
        check("reset_valid", 32'(bus.char_valid), 32'h0);
        check("reset_out",   32'(bus.char_out),   32'h0);
        check("reset_ovf",   32'(bus.overflow),   32'h0);
    endtask

    initial begin
        logic [7:0] glitch [7];
        logic [7:0] codes [4];
        logic [7:0] cur;
        bus.sign_value = '0;
        bus.sign_valid = 1'b0;
        bus.char_ready = 1'b0;

        // 1: reset with random inputs, then reset with three entries queued
        do_reset(2);
        for (int c = 0; c < 3; c++) begin
            for (int k = 0; k < STABLE; k++) frame(8'h61 + 8'(c), 1'b0);
        end
        check("pre_reset_count", 32'(bus.fifo_count), 32'd3);
        do_reset(1);

        // 2: basic accept under backpressure, long hold gives one character
        for (int k = 0; k < 3; k++) frame(8'h41, 1'b0);
        check("accept_early", 32'(bus.fifo_count), 32'd0);
        frame(8'h41, 1'b0);
        check("accept_count", 32'(bus.fifo_count), 32'd1);
        check("accept_char",  32'(bus.char_out),   32'h41);
        for (int k = 0; k < 10; k++) frame(8'h41, 1'b0);
        check("hold_count", 32'(bus.fifo_count), 32'd1);
        do_reset(1);

        // 3: glitch rejection
        glitch[0] = 8'h41; glitch[1] = 8'h41; glitch[2] = 8'h42; glitch[3] = 8'h41;
        glitch[4] = 8'h41; glitch[5] = 8'h41; glitch[6] = 8'h41;
        for (int k = 0; k < 6; k++) frame(glitch[k], 1'b0);
        check("glitch_none_yet", 32'(bus.fifo_count), 32'd0);
        frame(glitch[6], 1'b0);
        check("glitch_count", 32'(bus.fifo_count), 32'd1);
        check("glitch_char",  32'(bus.char_out),   32'h41);
        do_reset(1);

        // 4: repeat through NONE, with idle strobes between frames
        for (int k = 0; k < STABLE; k++) begin frame(8'h41, 1'b0); gap(1'b0); end
        frame(NONE, 1'b0); gap(1'b0);
        for (int k = 0; k < STABLE; k++) begin frame(8'h41, 1'b0); gap(1'b0); gap(1'b0); end
        check("repeat_count", 32'(bus.fifo_count), 32'd2);
        do_reset(1);

        // 5: overflow, then drain in order
        for (int c = 0; c < 9; c++) begin
            for (int k = 0; k < STABLE; k++) frame(8'h41 + 8'(c), 1'b0);
        end
        check("ovf_count", 32'(bus.fifo_count), 32'd8);
        check("ovf_flag",  32'(bus.overflow),   32'd1);
        for (int k = 0; k < DEPTH; k++) begin
            check("drain_order", 32'(bus.char_out), 32'h41 + 32'(k));
            gap(1'b1);
        end
        check("drained_count", 32'(bus.fifo_count), 32'd0);
        check("ovf_sticky",    32'(bus.overflow),   32'd1);
        do_reset(1);

        // 6: push and pop together while full
        for (int c = 0; c < DEPTH; c++) begin
            for (int k = 0; k < STABLE; k++) frame(8'h50 + 8'(c), 1'b0);
        end
        for (int k = 0; k < STABLE - 1; k++) frame(8'h5a, 1'b0);
        frame(8'h5a, 1'b1);
        check("full_pp_count", 32'(bus.fifo_count), 32'd8);
        check("full_pp_ovf",   32'(bus.overflow),   32'd0);
        for (int k = 0; k < DEPTH; k++) gap(1'b1);
        check("wrap_empty", 32'(bus.fifo_count), 32'd0);
        do_reset(1);

        // Random soak: held codes with random strobes, backpressure and rare resets
        codes[0] = NONE; codes[1] = 8'h41; codes[2] = 8'h42; codes[3] = 8'h43;
        cur = codes[1];
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 5) == 0) cur = codes[$urandom_range(0, 3)];
            tick($urandom_range(0, 2) != 0 ? cur : 8'($urandom),
                 1'b0, 1'($urandom_range(0, 3) == 0), 1'b0);
            tick(cur, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0),
                 1'($urandom_range(0, 399) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
